// File: rtl/quadrado_movimento_frame.sv
// quadrado_movimento_frame: frame-synchronous bouncing square position/size controller
module quadrado_movimento_frame #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       enable,
  input  logic [1:0] sw_vel,
  input  logic [1:0] sw_tam,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic [9:0] sq_size,
  output logic       frame_tick,
  output logic       colisao,
  output logic       canto
);
  typedef enum logic {NEG, POS} dir_t;
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  dir_t dir_x, dir_y, dir_x_d, dir_y_d;
  logic [1:0] vel_s1, vel_s2, tam_s1, tam_s2;
  logic [9:0] sz, nx, ny;
  logic [10:0] s, v, lim_x, lim_y, px, py;
  logic mv, bx, by;
  always_comb begin
    sz = 10'd16 << tam_s2;
    s = {1'b0, sz};
    v = vel_s2 == 2'b11 ? 11'd4 : {9'd0, vel_s2};
    lim_x = HA - s;
    lim_y = VA - s;
    px = {1'b0, sq_x} > lim_x ? lim_x : {1'b0, sq_x};
    py = {1'b0, sq_y} > lim_y ? lim_y : {1'b0, sq_y};
    mv = frame_tick && enable && vel_s2 != 2'b00;
    bx = mv && (dir_x == POS ? px + v + s >= HA : px <= v);
    by = mv && (dir_y == POS ? py + v + s >= VA : py <= v);
    nx = !mv ? px[9:0] : bx ? (dir_x == POS ? lim_x[9:0] : 10'd0)
       : 10'(dir_x == POS ? px + v : px - v);
    ny = !mv ? py[9:0] : by ? (dir_y == POS ? lim_y[9:0] : 10'd0)
       : 10'(dir_y == POS ? py + v : py - v);
    dir_x_d = bx ? (dir_x == POS ? NEG : POS) : dir_x;
    dir_y_d = by ? (dir_y == POS ? NEG : POS) : dir_y;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_x <= POS;
      dir_y <= POS;
    end else begin
      dir_x <= dir_x_d;
      dir_y <= dir_y_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vel_s1 <= '0;
      vel_s2 <= '0;
      tam_s1 <= '0;
      tam_s2 <= '0;
      sq_x <= 10'd312;
      sq_y <= 10'd232;
      sq_size <= 10'd16;
      frame_tick <= 1'b0;
      colisao <= 1'b0;
      canto <= 1'b0;
    end else begin
      vel_s1 <= sw_vel;
      vel_s2 <= vel_s1;
      tam_s1 <= sw_tam;
      tam_s2 <= tam_s1;
      frame_tick <= x == 10'd0 && y == 10'(V_ACTIVE);
      colisao <= bx || by;
      canto <= bx && by;
      if (frame_tick) begin
        sq_size <= sz;
        sq_x <= nx;
        sq_y <= ny;
      end
    end
  end
endmodule

// File: tb/tb_quadrado_movimento_frame.sv
// tb_quadrado_movimento_frame: scoreboard bench for the bouncing square controller
module tb_quadrado_movimento_frame;
  logic clk = 0, rst = 1, enable = 0;
  logic [9:0] x = 10'd5, y = 10'd0;
  logic [1:0] sw_vel = 0, sw_tam = 0;
  logic [9:0] sq_x, sq_y, sq_size;
  logic frame_tick, colisao, canto;

  quadrado_movimento_frame dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .enable(enable), .sw_vel(sw_vel),
    .sw_tam(sw_tam), .sq_x(sq_x), .sq_y(sq_y), .sq_size(sq_size),
    .frame_tick(frame_tick), .colisao(colisao), .canto(canto)
  );

  always #20 clk = ~clk;

  typedef struct {int x; int y; int s; int c; int k;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0, stray = 0;
  int mx, my, ms, mdx, mdy;
  bit last_ft = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    mx = 312; my = 232; ms = 16; mdx = 1; mdy = 1;
  endtask

  task automatic axis(input int p, input int lim, input int v, inout int d, output int n, output bit b);
    b = 0;
    if (d == 1) begin
      if (p + v + ms >= lim) begin n = lim - ms; d = 0; b = 1; end
      else n = p + v;
    end else begin
      if (p <= v) begin n = 0; d = 1; b = 1; end
      else n = p - v;
    end
  endtask

  task automatic model_update();
    exp_t e;
    int v, px, py;
    bit bx, by;
    v = sw_vel == 2'b11 ? 4 : int'(sw_vel);
    ms = 16 << sw_tam;
    px = mx < 640 - ms ? mx : 640 - ms;
    py = my < 480 - ms ? my : 480 - ms;
    bx = 0; by = 0;
    if (!enable || v == 0) begin mx = px; my = py; end
    else begin
      axis(px, 640, v, mdx, mx, bx);
      axis(py, 480, v, mdy, my, by);
    end
    e = '{mx, my, ms, int'(bx | by), int'(bx & by)};
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (last_ft && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_x", sq_x, e.x);
      chk("sb_y", sq_y, e.y);
      chk("sb_size", sq_size, e.s);
      chk("sb_colisao", colisao, e.c);
      chk("sb_canto", canto, e.k);
    end else if (!last_ft && (colisao || canto)) stray++;
    last_ft = frame_tick;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic marker();
    @(posedge clk); #1 x = 0; y = 480;
    @(negedge clk); chk("ft_pre", frame_tick, 0);
    model_update();
    @(posedge clk); #1 x = 5; y = 0;
    @(negedge clk); chk("ft", frame_tick, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; cycles(2); rst = 0; model_reset();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, sq_x, 312);
    chk({tag, "_y"}, sq_y, 232);
    chk({tag, "_size"}, sq_size, 16);
    chk({tag, "_pulses"}, {frame_tick, colisao, canto}, 0);
  endtask

  initial begin
    model_reset();
    cycles(2);
    @(negedge clk); chk_reset("rst");
    rst = 0; cycles(5);
    @(negedge clk); chk_reset("idle");
    sw_vel = 2'b01; sw_tam = 2'b00; enable = 1; cycles(3);
    marker();
    chk("lat_x", sq_x, 313);
    chk("lat_y", sq_y, 233);
    chk("lat_col", colisao, 0);
    cycles(3);
    chk("hold_x", sq_x, 313);
    sw_vel = 2'b11; do_reset(); cycles(3);
    for (int i = 1; i <= 78; i++) begin
      marker();
      if (i == 57) chk("m57_y", sq_y, 460);
      if (i == 58) begin
        chk("m58_y", sq_y, 464); chk("m58_col", colisao, 1); chk("m58_canto", canto, 0);
      end
      if (i == 77) chk("m77_x", sq_x, 620);
      if (i == 78) begin
        chk("m78_x", sq_x, 624); chk("m78_y", sq_y, 384); chk("m78_col", colisao, 1);
      end
    end
    sw_tam = 2'b11; cycles(3);
    marker();
    chk("rs_size", sq_size, 128);
    chk("rs_x", sq_x, 508);
    chk("rs_y", sq_y, 348);
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      marker(); chk("en0_x", sq_x, 508); chk("en0_y", sq_y, 348);
    end
    enable = 1; sw_vel = 2'b00; cycles(3);
    for (int i = 0; i < 3; i++) begin
      marker(); chk("v0_x", sq_x, 508); chk("v0_y", sq_y, 348);
    end
    sw_vel = 2'b10; sw_tam = 2'b01; cycles(3);
    for (int i = 0; i < 6; i++) marker();
    @(posedge clk); #1 x = 0; y = 480;
    @(posedge clk); #1 x = 5; y = 0; rst = 1;
    @(negedge clk); chk("mr_ft", frame_tick, 1);
    @(posedge clk); #1 rst = 0; model_reset();
    @(negedge clk); chk_reset("mr");
    cycles(4);
    @(negedge clk); chk_reset("mr_hold");
    chk("sb_drained", q.size(), 0);
    chk("stray_pulses", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/quadrado_movimento_frame.md
Name: quadrado_movimento_frame

Overview:
- Frame-synchronous position controller for the coloured square. It sits directly upstream of the square-drawing stage.
- Consumes the pixel counters x/y from the sequential VGA counter at the 25 MHz pixel clock.
- Produces the square's top-left corner and side length, updated once per frame during vertical blanking, so the picture never tears.
- The square bounces off the visible-area edges, with speed and size selected by switches.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- clk  input  1  25 MHz pixel clock, the same clock that drives the x/y counter. Single clock domain.
- rst  input  1  synchronous, active-high reset.
- x  input  10  current pixel column, 0..799.
- y  input  10  current line, 0..524.
- enable  input  1  1 = motion allowed; 0 = position frozen.
- sw_vel  input  2  speed select, asynchronous switch input.
- sw_tam  input  2  size select, asynchronous switch input.
- sq_x  output  10  square left column.
- sq_y  output  10  square top line.
- sq_size  output  10  square side length in pixels.
- frame_tick  output  1  one-cycle pulse marking the frame update.
- colisao  output  1  one-cycle pulse on any edge bounce.
- canto  output  1  one-cycle pulse when X and Y bounce in the same update.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Every register changes only on the rising edge of clk.
- Values after reset:
  - sq_x=312, sq_y=232, sq_size=16.
  - Direction flags dir_x=dir_y=1 (1 = increasing coordinate).
  - frame_tick=colisao=canto=0.
  - Switch synchronisers cleared to 0.
  - Reset asserted mid-frame restores these values on the next edge; no update is pending afterwards.
- Switch synchronisation: sw_vel and sw_tam each pass through a 2-flop synchroniser. Only the synchronised values are used.
- Frame marker:
  - frame_tick is a registered pulse, high for exactly the one cycle after the edge at which x==0 && y==V_ACTIVE is sampled.
  - Period is one per frame (420000 cycles with 800x525 timing).
  - frame_tick is generated regardless of enable.
- Decode:
  - Speed v: 00→0, 01→1, 10→2, 11→4 px/frame.
  - Size s: 00→16, 01→32, 10→64, 11→128.
- Update: performed on the edge that ends the frame_tick cycle, so outputs change one cycle after frame_tick. Order within the single update:
  1. sq_size ← s. Size is applied even when enable=0 or v=0.
  2. Clamp: px = min(sq_x, H_ACTIVE−s) and py = min(sq_y, V_ACTIVE−s).
  3. If enable=0 or v=0, store sq_x←px and sq_y←py, leave direction flags unchanged, and hold colisao=canto=0. Otherwise go to step 4.
  4. X axis, dir_x=1: if px+v+s ≥ H_ACTIVE then sq_x←H_ACTIVE−s and dir_x←0 (bounce); else sq_x←px+v.
  5. X axis, dir_x=0: if px ≤ v then sq_x←0 and dir_x←1 (bounce); else sq_x←px−v.
  6. Y axis: identical rules using py, V_ACTIVE and dir_y.
- Arithmetic width: all sums are computed 11 bits wide, so there is no wrap-around.
- Collision flags:
  - colisao=1 for one cycle, coincident with the new position, if either axis bounced.
  - canto=1 in the same cycle if both axes bounced.
- Between updates: all outputs are stable.
- State machine per axis: two states, POS and NEG. Transitions happen only at a bounce.

Test Plan:
- The bench drives x/y directly and produces one marker per "frame" (x=0, y=480 for one cycle).
- Reset: rst=1 for 2 cycles → sq_x=312, sq_y=232, sq_size=16, all pulses 0. Then rst=0 with no marker → outputs unchanged.
- Frame marker and latency: sw_vel=01, sw_tam=00, enable=1, one marker → frame_tick high exactly one cycle after the marker. On the following cycle sq_x=313, sq_y=233, colisao=0.
- Bounce sequence: after reset, sw_vel=11, sw_tam=00.
  - Marker 57 → sq_y=460.
  - Marker 58 → sq_y=464, dir_y=0, colisao=1, canto=0.
  - Marker 77 → sq_x=620.
  - Marker 78 → sq_x=624, sq_y=384, colisao=1.
- Resize with clamp: continue from marker 78 and set sw_tam=11. After ≥2 cycles, the next marker gives sq_size=128, sq_x=508, sq_y=348.
- Enable/zero speed: enable=0 across 3 markers → sq_x/sq_y hold, frame_tick still pulses each marker, colisao=0. Repeat with enable=1, sw_vel=00 → same result.
- Reset mid-operation: assert rst in the frame_tick cycle → next cycle shows reset values, with no update applied.
